// File: rtl/shift_seq_ctrl.sv
// Multi-cycle barrel-shift sequencer for the ALU shifter path.
// Iterates a single-step 32-bit shifter cell once per clock.
module shifter32b1 (
   input  logic [31:0] in,
   input  logic        shift,
   input  logic        dir,
   input  logic        arith,
   output logic [31:0] out
);
   logic fill;

   assign fill = arith & in[31];

   always_comb begin
      out = in;
      if (shift) begin
         if (dir) out = {in[30:0], 1'b0};
         else     out = {fill, in[31:1]};
      end
   end
endmodule

module shift_seq_ctrl #(
   parameter int SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [31:0]        in,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic               shiftdir,
   input  logic               shifta,
   output logic [31:0]        out,
   output logic               busy,
   output logic               done
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state, nxt;
   logic [31:0]        data, step;
   logic [SHAMT_W-1:0] cnt;
   logic               dir_q, arith_q;
   logic               accept, last;

   assign accept = (state == IDLE) && start;
   assign last   = (cnt == SHAMT_W'(1));

   shifter32b1 u_cell (
      .in    (data),
      .shift (1'b1),
      .dir   (dir_q),
      .arith (arith_q),
      .out   (step)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:    if (start) nxt = (shamt != '0) ? SHIFT : DONE;
         SHIFT:   if (last) nxt = DONE;
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
      done = (state == DONE);
   end

   // Operands are captured once on accept so later input changes are inert.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data    <= '0;
         cnt     <= '0;
         dir_q   <= 1'b0;
         arith_q <= 1'b0;
      end else if (accept) begin
         data    <= in;
         cnt     <= shamt;
         dir_q   <= shiftdir;
         arith_q <= shifta;
      end else if (state == SHIFT) begin
         data <= step;
         cnt  <= cnt - SHAMT_W'(1);
      end
   end

   assign out = data;
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl.
// Reference model plus directed literal checks.
module tb_shift_seq_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] in = '0;
   logic [4:0]  shamt = '0;
   logic        shiftdir = 1'b0;
   logic        shifta = 1'b0;
   logic [31:0] out;
   logic        busy, done;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int dcount = 0;
   bit armed = 0;

   // model state: busy cycles remaining and final result
   int          m_left = 0;
   logic [31:0] m_out = '0;

   shift_seq_ctrl #(.SHAMT_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in(in),
      .shamt(shamt), .shiftdir(shiftdir), .shifta(shifta),
      .out(out), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] ref_shift(
      input logic [31:0] v, input int n, input logic l, input logic a);
      if (l)      return v << n;
      else if (a) return 32'($signed(v) >>> n);
      else        return v >> n;
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         m_left = 0;
         m_out  = '0;
         armed  = 1;
      end else if (m_left == 0 && start) begin
         m_left = int'(shamt) + 1;
         m_out  = ref_shift(in, int'(shamt), shiftdir, shifta);
      end else if (m_left > 0) begin
         m_left = m_left - 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at cycle %0d",
                  name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (armed) begin
         chk("model_busy", 32'(busy), 32'(m_left > 0));
         chk("model_done", 32'(done), 32'(m_left == 1));
         if (m_left <= 1) chk("model_out", out, m_out);
      end
      if (done === 1'b1) dcount++;
   end

   task automatic wait_done(input string name, input int c0,
                            input int lat, input logic [31:0] exp);
      int n;
      n = 0;
      while (done !== 1'b1 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (done !== 1'b1) chk({name, "_timeout"}, 32'(0), 32'(1));
      else begin
         chk({name, "_lat"}, 32'(cyc - c0 + 1), 32'(lat));
         chk({name, "_out"}, out, exp);
      end
   endtask

   task automatic op(input string name, input logic [31:0] v,
                     input logic [4:0] s, input logic l, input logic a,
                     input int lat, input logic [31:0] exp);
      int c0;
      int d0;
      d0 = dcount;
      in = v; shamt = s; shiftdir = l; shifta = a; start = 1'b1;
      @(posedge clk); #1;
      c0 = cyc;
      start = 1'b0;
      wait_done(name, c0, lat, exp);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk({name, "_ndone"}, 32'(dcount - d0), 32'd1);
   endtask

   initial begin
      int c0;
      int d0;
      int dt[$];
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out", out, 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      op("left4", 32'h000000F1, 5'd4, 1'b1, 1'b0, 5, 32'h00000F10);
      op("rarith31", 32'h80000000, 5'd31, 1'b0, 1'b1, 32, 32'hFFFFFFFF);
      op("rlog31", 32'h80000000, 5'd31, 1'b0, 1'b0, 32, 32'h00000001);
      op("zero", 32'h12345678, 5'd0, 1'b0, 1'b0, 1, 32'h12345678);
      op("leftarith", 32'h80000001, 5'd1, 1'b1, 1'b1, 2, 32'h00000002);

      // isolation: inputs and start change while busy
      d0 = dcount;
      in = 32'hF0000000; shamt = 5'd8; shiftdir = 1'b0; shifta = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      c0 = cyc;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      in = 32'hFFFFFFFF; shamt = 5'd3; shiftdir = 1'b1; shifta = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done("iso", c0, 9, 32'h00F00000);
      repeat (6) @(posedge clk);
      #1;
      chk("iso_ndone", 32'(dcount - d0), 32'd1);

      // abort by reset mid-operation
      d0 = dcount;
      in = 32'h0000ABCD; shamt = 5'd10; shiftdir = 1'b1; shifta = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("abort_busy", 32'(busy), 32'h0);
      chk("abort_done", 32'(done), 32'h0);
      chk("abort_out", out, 32'h0);
      repeat (12) @(posedge clk);
      #1;
      chk("abort_ndone", 32'(dcount - d0), 32'd0);
      op("post_abort", 32'h00000001, 5'd1, 1'b1, 1'b0, 2, 32'h00000002);

      // back-to-back with start held high
      in = 32'h00000003; shamt = 5'd2; shiftdir = 1'b1; shifta = 1'b0;
      start = 1'b1;
      for (int i = 0; i < 14; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) begin
            dt.push_back(cyc);
            chk("b2b_out", out, 32'h0000000C);
         end
      end
      start = 1'b0;
      chk("b2b_count", 32'(dt.size()), 32'd3);
      for (int i = 1; i < dt.size(); i++)
         chk("b2b_gap", 32'(dt[i] - dt[i-1]), 32'd4);
      repeat (6) @(posedge clk);
      #1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
